alu_fifo_issue_ctrl: RTL and testbench

//  Issue controller sitting between the operand-A, operand-B and opcode FIFOs and the

---
 rtl/alu_fifo_pkg.sv | 29 ++
 rtl/alu_fifo_issue_ctrl_alu_core.sv | 25 ++
 rtl/alu_fifo_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_fifo_issue_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_fifo_pkg.sv
// rtl/alu_fifo_pkg.sv - shared opcode/state types for the ALU/FIFO issue controller
`ifndef OPCODE
`define OPCODE 2
`endif

package alu_fifo_pkg;

  localparam int OPC_W = `OPCODE + 1;

  typedef enum logic [OPC_W-1:0] {
    OPC_ADD = OPC_W'(0),
    OPC_SUB = OPC_W'(1),
    OPC_AND = OPC_W'(2),
    OPC_OR  = OPC_W'(3),
    OPC_XOR = OPC_W'(4),
    OPC_MUL = OPC_W'(5)
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    return opc <= OPC_W'(OPC_MUL);
  endfunction

endpackage

// File: rtl/alu_fifo_issue_ctrl_alu_core.sv
// rtl/alu_fifo_issue_ctrl_alu_core.sv - single-cycle ALU ops, zero for MUL and illegal codes
module alu_core
  import alu_fifo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [OPC_W-1:0] opc,
  output logic [W:0]       res
);

  always_comb begin
    res = '0;
    case (opcode_e'(opc))
      OPC_ADD: res = {1'b0, a} + {1'b0, b};
      OPC_SUB: res = {1'b0, a} - {1'b0, b};
      OPC_AND: res = {1'b0, a & b};
      OPC_OR:  res = {1'b0, a | b};
      OPC_XOR: res = {1'b0, a ^ b};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_fifo_issue_ctrl.sv
// rtl/alu_fifo_issue_ctrl.sv - joins A/B/opcode streams, issues ALU ops, pushes results
module alu_fifo_issue_ctrl
  import alu_fifo_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_n,
  input  logic [DATA_IN_WIDTH-1:0] op_a_i,
  input  logic                     op_a_valid_i,
  output logic                     op_a_ready_o,
  input  logic [DATA_IN_WIDTH-1:0] op_b_i,
  input  logic                     op_b_valid_i,
  output logic                     op_b_ready_o,
  input  logic [OPC_W-1:0]         opc_i,
  input  logic                     opc_valid_i,
  output logic                     opc_ready_o,
  output logic [DATA_IN_WIDTH:0]   res_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic                     err_o,
  output logic [CNT_WIDTH-1:0]     op_cnt_o
);

  localparam int W  = DATA_IN_WIDTH;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_e           state_q;
  logic [W:0]       res_q;
  logic             res_valid_q;
  logic             err_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2*W-1:0]   acc_q;
  logic [2*W-1:0]   mcand_q;
  logic [W-1:0]     mplier_q;
  logic [IW-1:0]    iter_q;

  logic             accept;
  logic [W:0]       alu_res;
  logic [2*W-1:0]   mul_sum;

  // Readies are held low while reset is asserted even if upstream is already valid.
  assign accept = arst_n && op_a_valid_i && op_b_valid_i && opc_valid_i &&
                  (state_q == ST_IDLE || (state_q == ST_DONE && res_ready_i));

  assign op_a_ready_o = accept;
  assign op_b_ready_o = accept;
  assign opc_ready_o  = accept;
  assign res_o        = res_q;
  assign res_valid_o  = res_valid_q;
  assign err_o        = err_q;
  assign op_cnt_o     = cnt_q;

  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  alu_core #(.W(W)) u_alu_core (
    .a   (op_a_i),
    .b   (op_b_i),
    .opc (opc_i),
    .res (alu_res)
  );

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      iter_q      <= '0;
    end else begin
      if (res_valid_q && res_ready_i)
        cnt_q <= cnt_q + CNT_WIDTH'(1);

      if (accept) begin
        if (!is_legal(opc_i))
          err_q <= 1'b1;
        if (opcode_e'(opc_i) == OPC_MUL) begin
          state_q     <= ST_MUL;
          res_valid_q <= 1'b0;
          acc_q       <= '0;
          mcand_q     <= {{W{1'b0}}, op_a_i};
          mplier_q    <= op_b_i;
          iter_q      <= '0;
        end else begin
          state_q     <= ST_DONE;
          res_valid_q <= 1'b1;
          res_q       <= alu_res;
        end
      end else begin
        case (state_q)
          ST_MUL: begin
            acc_q    <= mul_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            iter_q   <= iter_q + IW'(1);
            // Last iteration folds its partial product straight into the result.
            if (iter_q == IW'(W - 1)) begin
              state_q     <= ST_DONE;
              res_valid_q <= 1'b1;
              res_q       <= mul_sum[W:0];
            end
          end
          ST_DONE: begin
            if (res_ready_i) begin
              state_q     <= ST_IDLE;
              res_valid_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_fifo_issue_ctrl.sv
// tb/tb_alu_fifo_issue_ctrl.sv - directed self-checking bench for alu_fifo_issue_ctrl
module tb_alu_fifo_issue_ctrl;
  import alu_fifo_pkg::*;

  logic             clk_i = 1'b0;
  logic             arst_n;
  logic [7:0]       op_a_i, op_b_i;
  logic             op_a_valid_i, op_b_valid_i, opc_valid_i;
  logic             op_a_ready_o, op_b_ready_o, opc_ready_o;
  logic [OPC_W-1:0] opc_i;
  logic [8:0]       res_o;
  logic             res_valid_o, res_ready_i, err_o;
  logic [15:0]      op_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  alu_fifo_issue_ctrl #(.DATA_IN_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i        (clk_i),
    .arst_n       (arst_n),
    .op_a_i       (op_a_i),
    .op_a_valid_i (op_a_valid_i),
    .op_a_ready_o (op_a_ready_o),
    .op_b_i       (op_b_i),
    .op_b_valid_i (op_b_valid_i),
    .op_b_ready_o (op_b_ready_o),
    .opc_i        (opc_i),
    .opc_valid_i  (opc_valid_i),
    .opc_ready_o  (opc_ready_o),
    .res_o        (res_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .err_o        (err_o),
    .op_cnt_o     (op_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [OPC_W-1:0] opc,
                       input logic v);
    op_a_i = a; op_b_i = b; opc_i = opc;
    op_a_valid_i = v; op_b_valid_i = v; opc_valid_i = v;
  endtask

  function automatic logic [2:0] rdys();
    return {op_a_ready_o, op_b_ready_o, opc_ready_o};
  endfunction

  initial begin
    arst_n = 1'b0;
    res_ready_i = 1'b1;
    drive(8'h00, 8'h00, OPC_W'(0), 1'b1);
    #12;
    chk("rst_res", 32'(res_o), 32'h0);
    chk("rst_valid", 32'(res_valid_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_cnt", 32'(op_cnt_o), 32'h0);
    chk("rst_rdy", 32'(rdys()), 32'h0);
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);
    @(negedge clk_i);
    arst_n = 1'b1;
    tick();

    // 1: ADD carry-out
    drive(8'hFF, 8'h01, OPC_W'(0), 1'b1);
    #1;
    chk("add_rdy", 32'(rdys()), 32'h7);
    tick();
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);
    chk("add_valid", 32'(res_valid_o), 32'h1);
    chk("add_res", 32'(res_o), 32'h100);
    tick();
    chk("add_cnt", 32'(op_cnt_o), 32'h1);
    chk("add_idle", 32'(res_valid_o), 32'h0);

    // 2: SUB borrow, then partial valid set never pops
    drive(8'h03, 8'h05, OPC_W'(1), 1'b1);
    tick();
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);
    chk("sub_res", 32'(res_o), 32'h1FE);
    tick();
    op_a_valid_i = 1'b1; op_b_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("partial_rdy", 32'(rdys()), 32'h0);
      tick();
    end
    chk("partial_cnt", 32'(op_cnt_o), 32'h2);
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);

    // 3: MUL 0F*11, next ADD pending and accepted back-to-back
    drive(8'h0F, 8'h11, OPC_W'(5), 1'b1);
    #1;
    chk("mul_acc_rdy", 32'(rdys()), 32'h7);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) drive(8'h01, 8'h02, OPC_W'(0), 1'b1);
      #1;
      chk("mul_busy_rdy", 32'(rdys()), 32'h0);
      chk("mul_busy_valid", 32'(res_valid_o), 32'h0);
    end
    tick();
    chk("mul_valid", 32'(res_valid_o), 32'h1);
    chk("mul_res", 32'(res_o), 32'h0FF);
    chk("mul_b2b_rdy", 32'(rdys()), 32'h7);
    tick();
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);
    chk("b2b_res", 32'(res_o), 32'h003);
    chk("b2b_valid", 32'(res_valid_o), 32'h1);
    tick();
    chk("b2b_cnt", 32'(op_cnt_o), 32'h4);

    // 4: backpressure for 5 cycles with the next triple pending
    res_ready_i = 1'b0;
    drive(8'hF0, 8'hFF, OPC_W'(4), 1'b1);
    tick();
    drive(8'h3C, 8'h0F, OPC_W'(2), 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_res", 32'(res_o), 32'h00F);
      chk("hold_valid", 32'(res_valid_o), 32'h1);
      chk("hold_rdy", 32'(rdys()), 32'h0);
      tick();
    end
    res_ready_i = 1'b1;
    #1;
    chk("release_rdy", 32'(rdys()), 32'h7);
    chk("release_res", 32'(res_o), 32'h00F);
    tick();
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);
    chk("next_res", 32'(res_o), 32'h00C);
    chk("next_valid", 32'(res_valid_o), 32'h1);
    tick();
    chk("hold_cnt", 32'(op_cnt_o), 32'h6);

    // 5: illegal opcode is consumed, emits zero, sets sticky error
    drive(8'h12, 8'h34, OPC_W'(7), 1'b1);
    #1;
    chk("ill_rdy", 32'(rdys()), 32'h7);
    tick();
    drive(8'h01, 8'h01, OPC_W'(0), 1'b1);
    chk("ill_res", 32'(res_o), 32'h0);
    chk("ill_valid", 32'(res_valid_o), 32'h1);
    chk("ill_err", 32'(err_o), 32'h1);
    tick();
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);
    chk("post_ill_res", 32'(res_o), 32'h002);
    chk("err_sticky", 32'(err_o), 32'h1);
    tick();
    chk("ill_cnt", 32'(op_cnt_o), 32'h8);

    // 6: reset mid-MUL discards everything
    drive(8'h03, 8'h03, OPC_W'(5), 1'b1);
    tick();
    tick();
    tick();
    #2;
    arst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(res_valid_o), 32'h0);
    chk("mrst_res", 32'(res_o), 32'h0);
    chk("mrst_err", 32'(err_o), 32'h0);
    chk("mrst_cnt", 32'(op_cnt_o), 32'h0);
    chk("mrst_rdy", 32'(rdys()), 32'h0);
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);
    @(negedge clk_i);
    arst_n = 1'b1;
    tick();
    drive(8'h05, 8'h06, OPC_W'(0), 1'b1);
    tick();
    drive(8'h00, 8'h00, OPC_W'(0), 1'b0);
    chk("rec_res", 32'(res_o), 32'h00B);
    chk("rec_valid", 32'(res_valid_o), 32'h1);
    tick();
    chk("rec_cnt", 32'(op_cnt_o), 32'h1);
    chk("rec_err", 32'(err_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
